// File: rtl/tpu_pkg.sv
// ============================================================================
// Module : tpu_pkg
// Brief  : Shared defaults and fetch state encoding for the weight path.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package tpu_pkg;

    localparam int c_DEF_DATA_W = 16;
    localparam int c_DEF_LANES  = 4;
    localparam int c_BEATS_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/weight_buffer_if.sv
// ============================================================================
// Module : weight_buffer_if
// Brief  : Write port, fetch control and weight stream of the weight buffer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface weight_buffer_if import tpu_pkg::*; #(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int ADDR_W = 13,
    parameter int LANES  = c_DEF_LANES
);
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;
    logic                      start;
    logic [ADDR_W-1:0]         base_addr;
    logic [c_BEATS_W-1:0]      num_beats;
    logic                      w_ready;
    logic                      w_valid;
    logic [LANES*DATA_W-1:0]   w_data;
    logic                      busy;
    logic                      done;

    modport master (
        output wr_en, wr_addr, wr_data, start, base_addr, num_beats, w_ready,
        input  w_valid, w_data, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, base_addr, num_beats, w_ready,
        output w_valid, w_data, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/weight_mem_bank.sv
// ============================================================================
// Module : weight_mem_bank
// Brief  : DEPTH x DATA_W storage, one write port, LANES-wide wrapping read.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module weight_mem_bank #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int LANES  = 4,
    parameter int AW     = $clog2(DEPTH)
) (
    input  wire logic                    clk,
    input  wire logic                    i_we,
    input  wire logic [AW-1:0]           i_waddr,
    input  wire logic [DATA_W-1:0]       i_wdata,
    input  wire logic [AW-1:0]           i_raddr,
    output      logic [LANES*DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Contents are intentionally never reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Lane addresses wrap naturally because they are AW bits wide.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [AW-1:0] w_lane_addr;
        assign w_lane_addr = i_raddr + AW'(k);
        assign o_rdata[k*DATA_W +: DATA_W] = r_mem[w_lane_addr];
    end

endmodule

`default_nettype wire

// File: rtl/weight_buffer.sv
// ============================================================================
// Module : weight_buffer
// Brief  : Streams LANES-wide weight beats from local storage on request.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module weight_buffer import tpu_pkg::*; #(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int DEPTH  = 256,
    parameter int LANES  = c_DEF_LANES,
    parameter int ADDR_W = 13
) (
    input wire logic        clk,
    input wire logic        reset,
    weight_buffer_if.slave  bus
);

    localparam int              c_AW       = $clog2(DEPTH);
    localparam logic [c_AW-1:0] c_PTR_STEP = c_AW'(LANES % DEPTH);

    localparam logic [1:0] c_IDLE  = ST_IDLE;
    localparam logic [1:0] c_FETCH = ST_FETCH;
    localparam logic [1:0] c_DRAIN = ST_DRAIN;
    localparam logic [1:0] c_DONE  = ST_DONE;

    logic [1:0]              r_state;
    logic [c_AW-1:0]         r_ptr;
    logic [c_BEATS_W-1:0]    r_remaining;
    logic                    r_w_valid;
    logic [LANES*DATA_W-1:0] r_w_data;
    logic [LANES*DATA_W-1:0] w_rdata;
    logic                    w_load;
    logic                    w_mem_we;

    assign w_mem_we = bus.wr_en & ~reset;
    assign w_load   = ~r_w_valid | bus.w_ready;

    weight_mem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LANES  (LANES),
        .AW     (c_AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (bus.wr_addr[c_AW-1:0]),
        .i_wdata (bus.wr_data),
        .i_raddr (r_ptr),
        .o_rdata (w_rdata)
    );

    // Address bits above the storage depth are discarded (modulo DEPTH).
    if (ADDR_W > c_AW) begin : g_addr_hi
        logic w_unused_addr_hi;
        assign w_unused_addr_hi = ^{bus.wr_addr[ADDR_W-1:c_AW], bus.base_addr[ADDR_W-1:c_AW]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_w_valid   <= 1'b0;
            r_w_data    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        if (bus.num_beats != '0) begin
                            r_ptr       <= bus.base_addr[c_AW-1:0];
                            r_remaining <= bus.num_beats;
                            r_state     <= c_FETCH;
                        end else begin
                            r_state     <= c_DONE;
                        end
                    end
                end
                c_FETCH: begin
                    // Reading before the write edge gives read-before-write for free.
                    if (w_load) begin
                        r_w_data    <= w_rdata;
                        r_w_valid   <= 1'b1;
                        r_ptr       <= r_ptr + c_PTR_STEP;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == c_BEATS_W'(1)) begin
                            r_state <= c_DRAIN;
                        end
                    end
                end
                c_DRAIN: begin
                    if (bus.w_ready) begin
                        r_w_valid <= 1'b0;
                        r_state   <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.w_valid = r_w_valid;
    assign bus.w_data  = r_w_data;
    assign bus.busy    = (r_state != c_IDLE);
    assign bus.done    = (r_state == c_DONE);

endmodule

`default_nettype wire

// File: tb/tb_weight_buffer.sv
// ============================================================================
// Module : tb_weight_buffer
// Brief  : Self-checking bench: vector table, corner sequences, random fetches.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_weight_buffer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 256;
    localparam int LANES  = 4;
    localparam int ADDR_W = 13;
    localparam int LW     = LANES * DATA_W;

    logic clk = 1'b0;
    logic reset;

    weight_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) bus ();

    weight_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LANES  (LANES),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] model_mem [DEPTH];

    typedef struct {
        logic [ADDR_W-1:0] base;
        int                beats;
        int                mode;      // 0 ready, 1 random ready, 2 stall 2-4, 3 restart attempt, 4 same-cycle write
        bit                pre_wr;
        logic [LW-1:0]     exp_first;
        int                exp_done;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] pack(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        step();
        bus.wr_en   = 1'b0;
        model_mem[int'(addr) % DEPTH] = data;
    endtask

    // Runs one fetch; the expected beat stream is the word sequence base, base+1, ... mod DEPTH.
    task automatic fetch_check(input logic [ADDR_W-1:0] base, input int beats, input int mode,
                               output logic [LW-1:0] first, output int done_cyc);
        logic [DATA_W-1:0] exp_q [$];
        logic [LW-1:0]     exp_beat;
        logic [LW-1:0]     held;
        int                got;
        bit                stalled;
        first = '0; done_cyc = -1; got = 0; stalled = 1'b0; held = '0;
        for (int i = 0; i < beats * LANES; i++) exp_q.push_back(model_mem[(int'(base) + i) % DEPTH]);
        bus.start = 1'b1; bus.base_addr = base; bus.num_beats = 8'(beats); bus.w_ready = 1'b1;
        step();
        bus.start = 1'b0;
        for (int cyc = 1; cyc < 300 && done_cyc < 0; cyc++) begin
            case (mode)
                1:       bus.w_ready = 1'($urandom_range(0, 1));
                2:       bus.w_ready = !(cyc >= 2 && cyc <= 4);
                default: bus.w_ready = 1'b1;
            endcase
            if (mode == 3) begin
                bus.start = (cyc == 1); bus.base_addr = 13'h40; bus.num_beats = 8'd9;
            end
            if (mode == 4) begin
                bus.wr_en = (cyc == 1); bus.wr_addr = base + 13'd1; bus.wr_data = 16'h5A5A;
            end
            if (cyc == 1) chk("valid_cycle1", LW'(bus.w_valid), LW'(0));
            if (cyc == 2 && beats > 0) chk("valid_cycle2", LW'(bus.w_valid), LW'(1));
            if (stalled) chk("held_beat", {bus.w_valid, bus.w_data}, {1'b1, held});
            if (bus.w_valid && got >= beats) chk("extra_beat", LW'(got), LW'(beats - 1));
            else if (bus.w_valid && bus.w_ready) begin
                for (int k = 0; k < LANES; k++) exp_beat[k*DATA_W +: DATA_W] = exp_q[got*LANES + k];
                chk("beat_data", bus.w_data, exp_beat);
                if (got == 0) first = bus.w_data;
                got++;
            end
            stalled = bus.w_valid && !bus.w_ready;
            held    = bus.w_data;
            if (bus.done) begin
                done_cyc = cyc;
                chk("beat_count", LW'(got), LW'(beats));
                chk("valid_at_done", LW'(bus.w_valid), LW'(0));
            end
            step();
        end
        bus.wr_en = 1'b0; bus.start = 1'b0; bus.w_ready = 1'b1;
        if (mode == 4) model_mem[(int'(base) + 1) % DEPTH] = 16'h5A5A;
        if (done_cyc < 0) chk("done_timeout", LW'(0), LW'(1));
        chk("idle_after_done", LW'({bus.done, bus.busy}), LW'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [LW-1:0] first;
        int            dc;
        int            beats;
        int            mode;
        logic [ADDR_W-1:0] base;

        vecs[0] = '{13'h0000, 4, 0, 1'b0, pack(0, 1, 2, 3),          6};
        vecs[1] = '{13'h0000, 4, 2, 1'b0, pack(0, 1, 2, 3),          9};
        vecs[2] = '{13'h00FE, 1, 0, 1'b0, pack(254, 255, 0, 1),      3};
        vecs[3] = '{13'h0000, 0, 0, 1'b0, '0,                        1};
        vecs[4] = '{13'h000F, 1, 0, 1'b1, pack(3, 5, 4, 6),          3};
        vecs[5] = '{13'h010F, 1, 0, 1'b0, pack(3, 5, 4, 6),          3};
        vecs[6] = '{13'h1FFE, 2, 0, 1'b0, pack(254, 255, 0, 1),      4};
        vecs[7] = '{13'h000E, 2, 3, 1'b0, pack(14, 3, 5, 4),         4};

        reset = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.start = 1'b0; bus.base_addr = '0; bus.num_beats = '0; bus.w_ready = 1'b1;
        step(); step();
        reset = 1'b0;
        chk("reset_outputs", LW'({bus.w_valid, bus.busy, bus.done}), LW'(0));
        chk("reset_w_data", bus.w_data, '0);

        for (int i = 0; i < DEPTH; i++) do_write(ADDR_W'(i), DATA_W'(i));

        foreach (vecs[v]) begin
            if (vecs[v].pre_wr) begin
                do_write(13'h0F, 16'd3); do_write(13'h10, 16'd5);
                do_write(13'h11, 16'd4); do_write(13'h12, 16'd6);
            end
            fetch_check(vecs[v].base, vecs[v].beats, vecs[v].mode, first, dc);
            if (vecs[v].beats > 0) chk($sformatf("vec%0d_first", v), first, vecs[v].exp_first);
            chk($sformatf("vec%0d_done_cycle", v), LW'(dc), LW'(vecs[v].exp_done));
        end

        // Fetch and write to the same word in the same cycle: old word wins, new word lands.
        fetch_check(13'h20, 1, 4, first, dc);
        chk("rbw_old_word", first, pack(16'h20, 16'h21, 16'h22, 16'h23));
        fetch_check(13'h20, 1, 0, first, dc);
        chk("rbw_new_word", first, pack(16'h20, 16'h5A5A, 16'h22, 16'h23));

        // Reset while a beat is held; a write during reset must be ignored.
        bus.start = 1'b1; bus.base_addr = 13'h0; bus.num_beats = 8'd4; bus.w_ready = 1'b0;
        step();
        bus.start = 1'b0;
        step(); step();
        chk("held_before_reset", LW'(bus.w_valid), LW'(1));
        step();
        reset = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = 13'h0; bus.wr_data = 16'hDEAD;
        step();
        reset = 1'b0; bus.wr_en = 1'b0; bus.w_ready = 1'b1;
        chk("abort_outputs", LW'({bus.w_valid, bus.busy, bus.done}), LW'(0));
        chk("abort_w_data", bus.w_data, '0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_done", LW'({bus.done, bus.busy}), LW'(0));
            step();
        end
        fetch_check(13'h0, 1, 0, first, dc);
        chk("refetch_after_reset", first, pack(0, 1, 2, 3));

        for (int r = 0; r < 20; r++) begin
            for (int w = 0; w < 3; w++) do_write(ADDR_W'($urandom), DATA_W'($urandom));
            base  = ADDR_W'($urandom);
            beats = $urandom_range(0, 6);
            mode  = $urandom_range(0, 1);
            fetch_check(base, beats, mode, first, dc);
            if (mode == 0) chk("rand_done_cycle", LW'(dc), LW'((beats == 0) ? 1 : beats + 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/weight_buffer.md
WEIGHT_BUFFER -- requirements
Module: weight_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, weight word width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, words of storage, power of two.
REQ-003 SHALL have parameter LANES, default 4, weights delivered per beat, power of two, LANES <= DEPTH.
REQ-004 SHALL have parameter ADDR_W, default 13, address port width, ADDR_W >= log2(DEPTH).
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port wr_en, input, 1, write strobe.
REQ-008 SHALL have port wr_addr, input, ADDR_W, write word address.
REQ-009 SHALL have port wr_data, input, DATA_W, write word.
REQ-010 SHALL have port start, input, 1, one-cycle fetch request.
REQ-011 SHALL have port base_addr, input, ADDR_W, first word of fetch, sampled with start.
REQ-012 SHALL have port num_beats, input, 8, beats to fetch, sampled with start.
REQ-013 SHALL have port w_ready, input, 1, consumer accepts current beat.
REQ-014 SHALL have port w_valid, output, 1, w_data holds a valid beat.
REQ-015 SHALL have port w_data, output, LANES*DATA_W, lane k at bits [k*DATA_W +: DATA_W].
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-017 SHALL have port done, output, 1, one-cycle pulse at fetch completion.

Function
REQ-018 SHALL write wr_data to word (wr_addr mod DEPTH) on every clock with wr_en=1, in any state.
REQ-019 SHALL take all address arithmetic modulo DEPTH; lane reads crossing DEPTH-1 SHALL wrap to 0.
REQ-020 SHALL implement FSM IDLE, FETCH, DRAIN, DONE.
REQ-021 IDLE: start=1 with num_beats>0 SHALL latch base_addr/num_beats and go to FETCH; start=1 with num_beats=0 SHALL go to DONE directly.
REQ-022 SHALL ignore start in every state except IDLE.
REQ-023 FETCH: when w_valid=0 or (w_valid & w_ready), SHALL load w_data lane k with word (ptr+k) and set w_valid=1, then ptr += LANES and remaining -= 1.
REQ-024 SHALL hold w_data and w_valid stable while w_valid=1 and w_ready=0.
REQ-025 SHALL go FETCH->DRAIN on the cycle the final beat is loaded.
REQ-026 DRAIN: when w_ready=1, SHALL clear w_valid and go to DONE.
REQ-027 DONE: SHALL assert done for exactly one cycle, then go to IDLE.
REQ-028 SHALL give first beat w_valid=1 two cycles after the start cycle (start at cycle 0, w_valid at cycle 2).
REQ-029 SHALL sustain one beat per cycle while w_ready=1.
REQ-030 Write and fetch hitting the same word in the same cycle: the fetched beat SHALL contain the old word (read-before-write).
REQ-031 SHALL NOT assert w_valid outside FETCH and DRAIN.

Reset
REQ-032 reset=1 SHALL force state IDLE, w_valid=0, w_data=0, busy=0, done=0, ptr=0, remaining=0 on the next edge.
REQ-033 reset mid-fetch SHALL abort without done pulse; the held beat SHALL be dropped.
REQ-034 SHALL NOT clear storage contents on reset; wr_en SHALL be ignored while reset=1.

Structure
REQ-035 SHALL place DATA_W and LANES defaults and the FSM state enum in shared package tpu_pkg.
REQ-036 SHALL instantiate sub-module weight_mem_bank (DEPTH x DATA_W storage, one write port, LANES-wide wrapping read).
REQ-037 SHALL keep FSM, pointer, beat counter and output register in weight_buffer.

Verification
REQ-038 Write 3,5,4,6 to words 0x0F..0x12; start base=0x0F, beats=1, w_ready=1 -> cycle 2 w_data lanes {3,5,4,6}, done at cycle 3.
REQ-039 Write 0..15 to words 0..15; beats=4, base=0, w_ready=1 -> four consecutive beats {0-3},{4-7},{8-11},{12-15}, then done.
REQ-040 Same fill, w_ready low cycles 2-4 -> beat {0-3} held unchanged cycles 2-4, remaining beats follow with none lost or duplicated.
REQ-041 DEPTH=256, base=254, beats=1 -> lanes = words {254,255,0,1}.
REQ-042 start with beats=0 -> no w_valid; done the following cycle; second start while busy ignored.
REQ-043 reset asserted mid-fetch with w_ready=0 -> next edge w_valid=0, busy=0, no done; storage unchanged on refetch.
